writeback_stage: RTL

The writeback_stage holds the W pipeline register of the pipelined Y86-64 core and drives the register file's two write ports, E and M. It captures memory-stage results and applies the conditional-move squash. It also resolves same-register write conflicts, publishes a forwarding bus for decode, and latches the architectural status that stops the processor.

---
 rtl/y86_pkg.sv | 61 ++++++
 rtl/w_pipe_reg.sv | 42 ++++
 rtl/writeback_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the writeback slice.
//   - icode constants (HALT..POPQ)
//   - architectural status codes (AOK/HLT/ADR/INS)
//   - register IDs RNONE and RRSP
//   - w_reg_t: contents of the W pipeline register, and its bubble value
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IcodeHalt   = 4'h0;
    localparam logic [3:0] IcodeNop    = 4'h1;
    localparam logic [3:0] IcodeCmov   = 4'h2;
    localparam logic [3:0] IcodeIrmovq = 4'h3;
    localparam logic [3:0] IcodeRmmovq = 4'h4;
    localparam logic [3:0] IcodeMrmovq = 4'h5;
    localparam logic [3:0] IcodeOpq    = 4'h6;
    localparam logic [3:0] IcodeJxx    = 4'h7;
    localparam logic [3:0] IcodeCall   = 4'h8;
    localparam logic [3:0] IcodeRet    = 4'h9;
    localparam logic [3:0] IcodePushq  = 4'hA;
    localparam logic [3:0] IcodePopq   = 4'hB;

    // Architectural status codes
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    // Register IDs
    localparam logic [3:0] RNone = 4'hF;
    localparam logic [3:0] RRsp  = 4'h4;

    // W pipeline register contents
    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
    } w_reg_t;

    // NOP bubble: no destinations, clean status
    localparam w_reg_t WBubble = '{
        stat:  StatAok,
        icode: IcodeNop,
        dst_e: RNone,
        dst_m: RNone,
        val_e: 64'd0,
        val_m: 64'd0
    };

    // A destination ID of RNONE never writes
    function automatic logic reg_valid(input logic [3:0] id);
        return id != RNone;
    endfunction

    function automatic logic stat_ok(input logic [2:0] stat);
        return stat == StatAok;
    endfunction

endpackage

// File: rtl/w_pipe_reg.sv
// w_pipe_reg: generic stall/bubble pipeline register carrying a w_reg_t.
//   clk_i    : clock, updates on rising edge
//   rst_ni   : asynchronous active-low reset, loads the bubble
//   stall_i  : hold current contents (wins over bubble_i)
//   bubble_i : load the NOP bubble
//   d_i      : next contents when neither stall nor bubble
//   q_o      : current register contents
module w_pipe_reg
    import y86_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   stall_i,
    input  logic   bubble_i,
    input  w_reg_t d_i,
    output w_reg_t q_o
);

    w_reg_t w_d, w_q;

    always_comb begin
        w_d = w_q;
        if (stall_i) begin
            w_d = w_q;
        end else if (bubble_i) begin
            w_d = WBubble;
        end else begin
            w_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q <= WBubble;
        end else begin
            w_q <= w_d;
        end
    end

    assign q_o = w_q;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: W pipeline register of the Y86-64 core plus write-port control.
//   clk, reset (async, active-low)
//   W_stall, W_bubble                : pipeline control for the W register
//   M_stat/M_icode/M_cnd/M_dstE/M_dstM/M_valE/M_valM : memory-stage results
//   wE_en/wE_dst/wE_data             : register-file write port E
//   wM_en/wM_dst/wM_data             : register-file write port M
//   W_fwd_dstE/W_fwd_dstM/W_fwd_valE/W_fwd_valM : forwarding bus to decode
//   stat                             : current processor status (from W)
//   halted                           : sticky stop flag, cleared only by reset
module writeback_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valM,
    output logic        wE_en,
    output logic        wM_en,
    output logic [3:0]  wE_dst,
    output logic [3:0]  wM_dst,
    output logic [63:0] wE_data,
    output logic [63:0] wM_data,
    output logic [3:0]  W_fwd_dstE,
    output logic [3:0]  W_fwd_dstM,
    output logic [63:0] W_fwd_valE,
    output logic [63:0] W_fwd_valM,
    output logic [2:0]  stat,
    output logic        halted
);

    w_reg_t m_in;
    w_reg_t w_q;
    logic   halted_d, halted_q;
    logic   freeze;
    logic   write_ok;
    logic   conflict;
    logic   we_e, we_m;
    logic   unused_icode;

    // Memory-stage capture value, with the not-taken cmov squashed to RNONE
    always_comb begin
        m_in       = WBubble;
        m_in.stat  = M_stat;
        m_in.icode = M_icode;
        m_in.dst_e = (M_icode == IcodeCmov && !M_cnd) ? RNone : M_dstE;
        m_in.dst_m = M_dstM;
        m_in.val_e = M_valE;
        m_in.val_m = M_valM;
    end

    // A faulting instruction in W freezes the register on the same edge that
    // raises halted, so stat keeps the faulting value from then on.
    assign freeze = halted_q || !stat_ok(w_q.stat);

    w_pipe_reg u_w_reg (
        .clk_i    (clk),
        .rst_ni   (reset),
        .stall_i  (W_stall || freeze),
        .bubble_i (W_bubble),
        .d_i      (m_in),
        .q_o      (w_q)
    );

    always_comb begin
        halted_d = halted_q || !stat_ok(w_q.stat);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Same-register conflict (e.g. popq %rsp): the M port wins
    always_comb begin
        write_ok = stat_ok(w_q.stat) && !halted_q;
        conflict = reg_valid(w_q.dst_e) && (w_q.dst_e == w_q.dst_m);
        we_e     = write_ok && reg_valid(w_q.dst_e) && !conflict;
        we_m     = write_ok && reg_valid(w_q.dst_m);
    end

    assign wE_en   = we_e;
    assign wM_en   = we_m;
    assign wE_dst  = w_q.dst_e;
    assign wM_dst  = w_q.dst_m;
    assign wE_data = w_q.val_e;
    assign wM_data = w_q.val_m;

    assign W_fwd_dstE = we_e ? w_q.dst_e : RNone;
    assign W_fwd_dstM = we_m ? w_q.dst_m : RNone;
    assign W_fwd_valE = w_q.val_e;
    assign W_fwd_valM = w_q.val_m;

    assign stat   = w_q.stat;
    assign halted = halted_q;

    // icode travels with the instruction but no write decision depends on it
    assign unused_icode = ^w_q.icode;

endmodule
